// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync
//  Description : Single-clock first-in first-out buffer built on a DEPTH x DW
//                register array. It uses a write pointer and a read pointer,
//                each one bit wider than the array index. The extra MSB is a
//                wrap bit, so full and empty can be told apart even though
//                the index bits are equal in both cases. Read data is
//                registered and updates on the edge that accepts the read.
//
//  Optional    : FIFO_SYNC_STATUS_EN - when defined, adds the occupancy count
//                and the sticky overflow/underflow flags.
//
//  Ports
//    clk        in   1                single clock, rising-edge active
//    rst_n      in   1                asynchronous assert, active-low reset
//    w_en       in   1                write request
//    w_data     in   DW               write data
//    full       out  1                DEPTH entries stored
//    r_en       in   1                read request
//    r_data     out  DW               registered read data
//    empty      out  1                no entries stored
//    count      out  $clog2(DEPTH)+1  stored entries 0..DEPTH   (status only)
//    overflow   out  1                sticky: write rejected    (status only)
//    underflow  out  1                sticky: read rejected     (status only)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int DW    = 8,    // data width, >= 1
    parameter int DEPTH = 8     // entries, power of two, >= 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_en,
    input  logic [DW-1:0]            w_data,
    output logic                     full,
    input  logic                     r_en,
    output logic [DW-1:0]            r_data,
    output logic                     empty
`ifdef FIFO_SYNC_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_AW = $clog2(DEPTH);    // index width
    localparam int c_PW = c_AW + 1;         // pointer width incl. wrap bit

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [DW-1:0]   r_rdata;

    // ------------------------------------------------------------------------
    // Flag decode. Both flags come purely from the registered pointers, so
    // they are stable for the whole cycle and qualify requests on the edge.
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_empty  = (r_wptr == r_rptr);
    // Same slot but the writer is one lap ahead of the reader.
    assign w_full   = (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]) &&
                      (r_wptr[c_AW]     != r_rptr[c_AW]);

    // Each request is qualified only by its own flag as it stands before the
    // edge. A read from a full FIFO does not open room for a write on the
    // same edge, and a write to an empty FIFO cannot be read on that edge.
    assign w_wr_acc = w_en & ~w_full;
    assign w_rd_acc = r_en & ~w_empty;

    // ------------------------------------------------------------------------
    // Storage array. It is intentionally not reset. Stale contents are never
    // visible because the pointers decide what counts as valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr[c_AW-1:0]] <= w_data;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers. They wrap naturally modulo 2*DEPTH. Because DEPTH is a power
    // of two, the index bits also wrap modulo DEPTH.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered read data. It holds its value whenever no read is accepted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_rd_acc) begin
            r_rdata <= r_mem[r_rptr[c_AW-1:0]];
        end
    end

    assign r_data = r_rdata;
    assign empty  = w_empty;
    assign full   = w_full;

`ifdef FIFO_SYNC_STATUS_EN
    // ------------------------------------------------------------------------
    // Status: occupancy and sticky error flags
    // ------------------------------------------------------------------------
    logic r_overflow;
    logic r_underflow;

    // Pointer difference modulo 2*DEPTH. This is exactly 0..DEPTH because
    // the writer is never more than one lap ahead of the reader.
    assign count = r_wptr - r_rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_sync
//  Description : Self-checking bench for fifo_sync (DW=8, DEPTH=8). It uses
//                directed scenarios followed by a randomized phase. The
//                reference model is a plain queue with the occupancy rules of
//                a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          full;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic          empty;
`ifdef FIFO_SYNC_STATUS_EN
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;
`endif

    fifo_sync #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_en      (w_en),
        .w_data    (w_data),
        .full      (full),
        .r_en      (r_en),
        .r_data    (r_data),
        .empty     (empty)
`ifdef FIFO_SYNC_STATUS_EN
        ,
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int            q[$];
    logic [DW-1:0] m_rdata;
    bit            m_ovf;
    bit            m_unf;

    int n_total = 0;
    int n_pass  = 0;

    task automatic model_reset();
        q.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".empty"},  32'(empty),  32'(q.size() == 0));
        check({tag, ".full"},   32'(full),   32'(q.size() == DEPTH));
        check({tag, ".r_data"}, 32'(r_data), 32'(m_rdata));
`ifdef FIFO_SYNC_STATUS_EN
        check({tag, ".count"},     32'(count),     32'(q.size()));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
`endif
    endtask

    // One clock: the model applies the FIFO rules to the inputs present at
    // the edge, using its occupancy from before the edge. The DUT outputs are
    // then checked 1 time unit after that edge.
    task automatic step(input string tag);
        bit pre_full;
        bit pre_empty;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            pre_full  = (q.size() == DEPTH);
            pre_empty = (q.size() == 0);
            if (r_en && !pre_empty) m_rdata = DW'(q.pop_front());
            if (w_en && !pre_full)  q.push_back(int'(w_data));
            if (w_en && pre_full)   m_ovf = 1'b1;
            if (r_en && pre_empty)  m_unf = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic we, input logic re, input logic [DW-1:0] d);
        w_en   = we;
        r_en   = re;
        w_data = d;
    endtask

    initial begin
        rst_n  = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        w_data = '0;
        model_reset();

        // Reset held for two cycles, then released away from the edge.
        step("reset0");
        step("reset1");
        rst_n = 1'b1;
        step("post_reset");

        // Order: write 10..14, then read them back.
        for (int i = 10; i <= 14; i++) begin
            drive(1'b1, 1'b0, DW'(i));
            step("order_wr");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, '0);
            step("order_rd");
        end

        // Full: write 8 values, attempt a 9th (99), then drain.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, DW'(40 + i));
            step("full_wr");
        end
        drive(1'b1, 1'b0, DW'(99));
        step("full_reject");
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, '0);
            step("full_rd");
        end

        // Empty read: three rejected reads leave r_data untouched.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, '0);
            step("empty_rd");
        end

        // Simultaneous: with four entries stored, read and write together.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, DW'(60 + i));
            step("simul_fill");
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, DW'(70 + i));
            step("simul_rw");
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, '0);
            step("simul_drain");
        end

        // Wrap: stream 0..19 while keeping occupancy at 3 or fewer.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, q.size() >= 2, DW'(i));
            step("wrap_stream");
        end
        while (q.size() > 0) begin
            drive(1'b0, 1'b1, '0);
            step("wrap_drain");
        end

        // Reset asserted mid-stream, between clock edges.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, q.size() >= 2, DW'(100 + i));
            step("midrst_stream");
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async_reset");
        drive(1'b0, 1'b0, '0);
        step("in_reset");
        rst_n = 1'b1;
        drive(1'b1, 1'b0, DW'(123));
        step("first_write");
        drive(1'b0, 1'b1, '0);
        step("first_read");

        // Randomized traffic. The phases are biased toward filling and toward
        // draining so that both boundaries are hit repeatedly.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = ((i / 40) % 2 == 0) ? 75 : 25;
            drive($urandom_range(0, 99) < bias,
                  $urandom_range(0, 99) >= bias,
                  DW'($urandom));
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter DW, default 8: data width in bits, at least 1.
REQ-002 Parameter DEPTH, default 8: number of entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 w_en  input  1  write request.
REQ-006 w_data  input  DW  write data.
REQ-007 full  output  1  high when DEPTH entries are stored.
REQ-008 r_en  input  1  read request.
REQ-009 r_data  output  DW  registered read data.
REQ-010 empty  output  1  high when zero entries are stored.
REQ-011 Ports present only with FIFO_SYNC_STATUS_EN:
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky flag.
- underflow  output  1  sticky flag.

Function
REQ-012 Storage: DEPTH x DW register array; write pointer and read pointer, each $clog2(DEPTH)+1 bits (MSB is the wrap bit).
REQ-013 Write accepted on a rising edge when w_en=1 and full=0: mem[wptr index] <= w_data, then wptr increments.
REQ-014 Read accepted on a rising edge when r_en=1 and empty=0: r_data <= mem[rptr index], then rptr increments.
REQ-015 Read latency: r_data takes the new value at the accepting edge and is valid immediately after that edge; r_data holds its value when no read is accepted.
REQ-016 empty = (wptr == rptr), decoded combinationally from registered pointers.
REQ-017 full = (index bits equal, wrap bits differ), decoded combinationally from registered pointers.
REQ-018 Data is strictly first-in first-out. Pointer indices wrap modulo DEPTH without loss or reordering.
REQ-019 Write while full is ignored: no state change, no corruption.
REQ-020 Read while empty is ignored: pointers and r_data unchanged.
REQ-021 Simultaneous w_en and r_en: each is qualified by the flags sampled before the edge.
- Neither full nor empty: both are accepted and occupancy is unchanged.
- Full: only the read is accepted.
- Empty: only the write is accepted.

Reset
REQ-022 rst_n=0 immediately clears both pointers and r_data=0, giving empty=1 and full=0, regardless of clk.
REQ-023 When FIFO_SYNC_STATUS_EN is defined, reset also clears count=0, overflow=0 and underflow=0.
REQ-024 Memory contents are not reset. Reset asserted mid-operation discards all stored entries.
REQ-025 Deassertion of rst_n takes effect at the next rising edge; the first write may occur on the first edge after deassertion.

Configuration
REQ-026 Macro FIFO_SYNC_STATUS_EN defined:
- count equals wptr - rptr, modulo 2*DEPTH.
- overflow sets on a rejected write (w_en=1 while full=1).
- underflow sets on a rejected read (r_en=1 while empty=1).
- Both flags hold until reset.
REQ-027 Macro FIFO_SYNC_STATUS_EN undefined: count, overflow and underflow ports and logic are absent; all other behaviour is identical.

Verification
REQ-028 The bench shall cover the following scenarios (DW=8, DEPTH=8 unless stated).
- Reset: hold rst_n=0 for 2 cycles, then release -> empty=1, full=0, r_data=0.
- Order: write 10,11,12,13,14 on consecutive edges, then read 5 times -> r_data sequence is 10..14; empty=1 after the fifth read.
- Full: write 8 values, then attempt a 9th (value 99) -> full=1 after the 8th write; reading back returns the first 8 values only; overflow=1 if the macro is defined.
- Empty read: r_en=1 for 3 cycles with the FIFO empty -> r_data holds its prior value, empty stays 1; underflow=1 if the macro is defined.
- Simultaneous: with 4 entries stored, assert w_en and r_en for 10 cycles -> occupancy stays 4 (count=4), data order preserved.
- Wrap and reset: stream 0..19 through the FIFO with occupancy kept at 3 or fewer -> outputs are 0..19 in order; asserting rst_n mid-stream asynchronously forces empty=1 and r_data=0.
